spi_flash_reader: RTL and testbench
===================================

Name: spi_flash_reader

Overview:
Wishbone-side SPI flash read initiator: the host end of the serial-flash interface whose responder is the spiflash model used in the chip-level benches. It accepts a (byte address, word count) request, optionally issues a one-time 0xAB release-from-power-down, then runs a standard 0x03 READ transaction in SPI mode 0. Read data is returned as little-endian 32-bit words over a valid/ready stream. It sits between the boot/ROM fetch logic and the flash_csb/flash_clk/flash_io0/flash_io1 pads.

Parameters:
CLK_DIV, 1, SCK half-period in clock cycles (>=1); SCK frequency = clock/(2*CLK_DIV)
LEN_W, 8, width of the word-count field
CS_GAP, 4, minimum clock cycles flash_csb stays high between transactions (>=1)
WAKEUP, 1, 1 = send 0xAB once after reset before the first READ

Ports:
clock  in  1  single clock
resetb  in  1  asynchronous active-low reset
req_valid  in  1  read request valid
req_ready  out  1  high only in IDLE with the gap satisfied
req_addr  in  24  flash byte address
req_len  in  LEN_W  number of 32-bit words to read; 0 is treated as 1
rd_valid  out  1  read word valid
rd_ready  in  1  consumer accepts the word
rd_data  out  32  word; byte0 = first byte received, in bits [7:0]
rd_last  out  1  marks the final word of the request
busy  out  1  high from request acceptance until return to IDLE
flash_csb  out  1  chip select, active low
flash_clk  out  1  SCK, idles low (mode 0)
flash_io0  out  1  MOSI
flash_io1  in  1  MISO

Behaviour:
- Reset (async assert, sync release): flash_csb=1, flash_clk=0, flash_io0=0, rd_valid=0, rd_last=0, rd_data=0, busy=0, req_ready=0 until the CS_GAP count expires, wake-pending flag = WAKEUP.
- Reset mid-transaction: flash_csb goes high immediately; no word is output; the next request restarts cleanly, with a fresh wake-up if WAKEUP=1.
- FSM states: IDLE, WAKE, WGAP, CMD, DATA, HOLD, GAP.
- IDLE: a request is accepted on req_valid&&req_ready. The block latches addr and len, asserts busy, and drives flash_csb low on the next cycle. It goes to WAKE if wake-pending is set, else to CMD.
- WAKE: shifts 8 bits of 0xAB, MSB first. It then raises csb, clears wake-pending, and goes to WGAP.
- WGAP: holds csb high for CS_GAP cycles, drops csb, then goes to CMD.
- CMD: shifts 32 bits MSB first: 0x03 followed by addr[23:16], addr[15:8], addr[7:0].
- Bit timing (SCK): io0 changes only while SCK is low. The first bit is valid at csb assertion, and each later bit changes with the SCK fall. SCK toggles every CLK_DIV cycles. Each bit is one low phase plus one high phase.
- DATA: io0 is held 0. io1 is sampled in the cycle SCK goes 0->1, MSB first within each byte. Bytes are packed little-endian into a 32-bit word.
- When the 4th byte completes on the final SCK rise, the word is presented with rd_valid=1 while SCK is still high; rd_last=1 if it is the final word.
- If the word is not the last: the block keeps clocking the next word's bits while the previous word is unconsumed.
- HOLD: entered if a new word completes while rd_valid is still high and rd_ready is low. SCK is frozen low after its next fall, with csb kept low. Shifting resumes on the cycle after the pending word is accepted. There is no data loss and no extra SCK edges.
- Last word: on its completion, csb rises on the next SCK-low phase and the FSM goes to GAP. rd_valid stays high until the handshake.
- GAP: csb is held high for CS_GAP cycles. The FSM returns to IDLE only once the last word has been accepted. busy drops on entry to IDLE.
- rd_valid/rd_data/rd_last are stable while rd_valid&&!rd_ready. req_valid is ignored while busy.
- Counters: bit counter 0..31 (6 bits), word counter LEN_W bits counting down. req_len=0 maps to 1. Max transfer is 2^LEN_W-1 words, with no address wrap handling; the flash wraps internally.
- Total SCK cycles per request = 32 + 32*len, plus 8 if a wake-up is sent.

Decomposition:
- Shared package spi_flash_pkg: state enum, constants CMD_READ=8'h03 and CMD_WAKE=8'hAB, and bit-count constants.
- One natural sub-module: spi_sck_gen. It takes CLK_DIV, run, and freeze inputs, and emits sck, rise_pulse and fall_pulse.
- The FSM, shifters and output register stay in spi_flash_reader.

Test Plan:
- Wake + single read: flash hex words 0x00000013 at 0x0, 0xDEADBEEF at 0x4. Request addr=0x000004, len=1. Check MOSI bytes AB, then csb high >=4 cycles, then 03 00 00 04. Check rd_data=0xDEADBEEF with rd_last=1, and exactly 72 SCK rises total.
- Burst without wake: second request addr=0x000000, len=4, with rd_ready tied 1. Check 4 words equal the hex contents in order, rd_last only on word 4, no 0xAB, and 160 SCK rises.
- Backpressure: len=3, rd_ready low for 200 cycles after word 1. Check SCK frozen low with csb low (HOLD), then no lost or duplicated words, and data matches.
- CLK_DIV=3: check SCK high and low each last exactly 3 cycles, io0 never changes while SCK is high, and data is correct.
- Reset mid-DATA: assert resetb=0 after 10 data bits. Check csb=1 and clk=0 asynchronously and rd_valid=0. After release, check the next request resends 0xAB and returns correct data.
- req_len=0 and back-to-back requests: len=0 yields exactly 1 word. A new req_valid held high is accepted only after CS_GAP cycles of csb high.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash read initiator.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAKE = 3'd1,
    ST_WGAP = 3'd2,
    ST_CMD  = 3'd3,
    ST_DATA = 3'd4,
    ST_HOLD = 3'd5,
    ST_GAP  = 3'd6
  } state_t;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_WAKE = 8'hAB;

  localparam logic [5:0] WAKE_BITS = 6'd8;
  localparam logic [5:0] CMD_BITS  = 6'd32;
  localparam logic [5:0] WORD_BITS = 6'd32;

  // READ opcode followed by the 24-bit address, sent MSB first.
  function automatic logic [31:0] read_cmd(input logic [23:0] addr);
    return {CMD_READ, addr};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Mode-0 SCK generator: half-period of CLK_DIV cycles, can be frozen low.
module spi_sck_gen
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic clock,
  input  logic resetb,
  input  logic run,
  input  logic freeze,
  output logic sck,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          hold_low;
  logic          tick;

  // A freeze request lets a high phase finish and then parks SCK low.
  assign hold_low   = freeze && !sck;
  assign tick       = run && !hold_low && (cnt == CW'(CLK_DIV - 1));
  assign rise_pulse = tick && !sck;
  assign fall_pulse = tick && sck;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (hold_low) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI flash READ (0x03) initiator with one-shot 0xAB wake-up, returning
// little-endian 32-bit words on a valid/ready stream.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int LEN_W   = 8,
  parameter int CS_GAP  = 4,
  parameter int WAKEUP  = 1
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [31:0]      rd_data,
  output logic             rd_last,
  output logic             busy,
  output logic             flash_csb,
  output logic             flash_clk,
  output logic             flash_io0,
  input  logic             flash_io1,
  output logic [2:0]       state_dbg
);

  // Handshakes: a transfer happens on a clock edge where valid && ready are
  // both high; once valid is raised its payload is held until that edge.

  localparam int GW = $clog2(CS_GAP + 1);

  state_t           state;
  logic             wake_pend;
  logic             run;
  logic             freeze;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [31:0]      tx_sh;
  logic [5:0]       bit_cnt;
  logic [5:0]       shift_bits;
  logic [31:0]      word_sh;
  logic [31:0]      word_next;
  logic             word_done;
  logic             out_free;
  logic [LEN_W-1:0] words_left;
  logic [23:0]      addr_q;
  logic [31:0]      cmd_new;
  logic [31:0]      cmd_q;
  logic             last_pend;
  logic             fin;
  logic [GW-1:0]    gap_cnt;
  logic             gap_ok;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clock      (clock),
    .resetb     (resetb),
    .run        (run),
    .freeze     (freeze),
    .sck        (flash_clk),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  assign state_dbg = state;

  always_comb begin
    cmd_new    = read_cmd(req_addr);
    cmd_q      = read_cmd(addr_q);
    shift_bits = (state == ST_WAKE) ? WAKE_BITS : CMD_BITS;
    out_free   = !rd_valid || rd_ready;
    word_done  = rise_pulse && (bit_cnt == WORD_BITS - 6'd1);
    // Bit b of the stream is bit 7-(b%8) of byte b/8 in the word.
    word_next  = word_sh;
    word_next[{bit_cnt[4:3], ~bit_cnt[2:0]}] = flash_io1;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state      <= ST_IDLE;
      wake_pend  <= (WAKEUP != 0);
      flash_csb  <= 1'b1;
      flash_io0  <= 1'b0;
      run        <= 1'b0;
      freeze     <= 1'b0;
      busy       <= 1'b0;
      req_ready  <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_last    <= 1'b0;
      tx_sh      <= '0;
      bit_cnt    <= '0;
      word_sh    <= '0;
      words_left <= '0;
      addr_q     <= '0;
      last_pend  <= 1'b0;
      fin        <= 1'b0;
      gap_cnt    <= '0;
      gap_ok     <= 1'b0;
    end else begin
      if (rd_valid && rd_ready) rd_valid <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (!gap_ok) begin
            gap_cnt <= gap_cnt + GW'(1);
            if (gap_cnt == GW'(CS_GAP - 1)) begin
              gap_ok    <= 1'b1;
              req_ready <= 1'b1;
            end
          end else if (req_valid && req_ready) begin
            addr_q     <= req_addr;
            words_left <= (req_len == '0) ? LEN_W'(1) : req_len;
            busy       <= 1'b1;
            req_ready  <= 1'b0;
            gap_ok     <= 1'b0;
            gap_cnt    <= '0;
            flash_csb  <= 1'b0;
            run        <= 1'b1;
            bit_cnt    <= '0;
            fin        <= 1'b0;
            if (wake_pend) begin
              state     <= ST_WAKE;
              flash_io0 <= CMD_WAKE[7];
              tx_sh     <= {CMD_WAKE[6:0], 25'd0};
            end else begin
              state     <= ST_CMD;
              flash_io0 <= cmd_new[31];
              tx_sh     <= {cmd_new[30:0], 1'b0};
            end
          end
        end

        ST_WAKE, ST_CMD: begin
          if (rise_pulse) bit_cnt <= bit_cnt + 6'd1;
          if (fall_pulse) begin
            if (bit_cnt == shift_bits) begin
              flash_io0 <= 1'b0;
              bit_cnt   <= '0;
              if (state == ST_WAKE) begin
                flash_csb <= 1'b1;
                run       <= 1'b0;
                wake_pend <= 1'b0;
                gap_cnt   <= '0;
                state     <= ST_WGAP;
              end else begin
                state <= ST_DATA;
              end
            end else begin
              flash_io0 <= tx_sh[31];
              tx_sh     <= {tx_sh[30:0], 1'b0};
            end
          end
        end

        ST_WGAP: begin
          gap_cnt <= gap_cnt + GW'(1);
          if (gap_cnt == GW'(CS_GAP - 1)) begin
            gap_cnt   <= '0;
            flash_csb <= 1'b0;
            run       <= 1'b1;
            bit_cnt   <= '0;
            flash_io0 <= cmd_q[31];
            tx_sh     <= {cmd_q[30:0], 1'b0};
            state     <= ST_CMD;
          end
        end

        ST_DATA: begin
          if (fin) begin
            // Last word captured: release the flash once SCK is low.
            if (fall_pulse || !flash_clk) begin
              flash_csb <= 1'b1;
              run       <= 1'b0;
              freeze    <= 1'b0;
              gap_cnt   <= '0;
              state     <= ST_GAP;
            end
          end else if (rise_pulse) begin
            word_sh <= word_next;
            bit_cnt <= word_done ? 6'd0 : bit_cnt + 6'd1;
            if (word_done) begin
              words_left <= words_left - LEN_W'(1);
              if (out_free) begin
                rd_valid <= 1'b1;
                rd_data  <= word_next;
                rd_last  <= (words_left == LEN_W'(1));
                fin      <= (words_left == LEN_W'(1));
              end else begin
                last_pend <= (words_left == LEN_W'(1));
                freeze    <= 1'b1;
                state     <= ST_HOLD;
              end
            end
          end
        end

        ST_HOLD: begin
          if (rd_ready) begin
            rd_valid <= 1'b1;
            rd_data  <= word_sh;
            rd_last  <= last_pend;
            state    <= ST_DATA;
            if (last_pend) fin <= 1'b1;
            else freeze <= 1'b0;
          end
        end

        ST_GAP: begin
          if (!gap_ok) begin
            gap_cnt <= gap_cnt + GW'(1);
            if (gap_cnt == GW'(CS_GAP - 1)) gap_ok <= 1'b1;
          end else if (!rd_valid) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural mode-0 flash model.
module tb_spi_flash_reader;

  localparam int CLK_DIV = 3;
  localparam int LEN_W   = 8;
  localparam int CS_GAP  = 4;
  localparam int WAKEUP  = 1;

  logic             clock = 1'b0;
  logic             resetb = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [23:0]      req_addr = '0;
  logic [LEN_W-1:0] req_len = '0;
  logic             rd_valid;
  logic             rd_ready = 1'b1;
  logic [31:0]      rd_data;
  logic             rd_last;
  logic             busy;
  logic             flash_csb;
  logic             flash_clk;
  logic             flash_io0;
  logic             flash_io1 = 1'b0;
  logic [2:0]       state_dbg;

  always #5 clock = ~clock;

  spi_flash_reader #(
    .CLK_DIV(CLK_DIV), .LEN_W(LEN_W), .CS_GAP(CS_GAP), .WAKEUP(WAKEUP)
  ) dut (
    .clock(clock), .resetb(resetb),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last), .busy(busy),
    .flash_csb(flash_csb), .flash_clk(flash_clk),
    .flash_io0(flash_io0), .flash_io1(flash_io1),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard bookkeeping ----------------
  logic [31:0] mem_w [0:7];
  logic [32:0] exp_q [$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_wait(input string name);
    n_total++;
    $display("FAIL %s: wait expired before the DUT event", name);
  endtask

  initial begin
    mem_w[0] = 32'h00000013; mem_w[1] = 32'hDEADBEEF;
    mem_w[2] = 32'h12345678; mem_w[3] = 32'hCAFEF00D;
    mem_w[4] = 32'h0BADC0DE; mem_w[5] = 32'hA5A55A5A;
    mem_w[6] = 32'h0F1E2D3C; mem_w[7] = 32'h89ABCDEF;
  end

  // ---------------- flash model ----------------
  int          fbits = 0;
  int          sck_rises = 0;
  logic [31:0] mosi_sh = '0;
  logic [7:0]  fcmd = '0;
  logic [23:0] faddr = '0;
  logic [7:0]  mosi_log [$];
  int          f_idx;
  logic [23:0] f_ba;
  logic [31:0] f_wsh;

  always @(negedge flash_csb) begin
    fbits = 0;
    fcmd  = '0;
  end

  always @(posedge flash_clk) begin
    if (!flash_csb) begin
      sck_rises++;
      mosi_sh = {mosi_sh[30:0], flash_io0};
      fbits++;
      if (fbits == 8) begin
        fcmd = mosi_sh[7:0];
        mosi_log.push_back(mosi_sh[7:0]);
      end else if (fcmd == 8'h03 && (fbits inside {16, 24, 32})) begin
        mosi_log.push_back(mosi_sh[7:0]);
        if (fbits == 32) faddr = mosi_sh[23:0];
      end
    end
  end

  always @(negedge flash_clk) begin
    if (!flash_csb && fcmd == 8'h03 && fbits >= 32) begin
      f_idx = fbits - 32;
      f_ba  = faddr + 24'(f_idx / 8);
      f_wsh = mem_w[f_ba[4:2]] >> (8 * f_ba[1:0]);
      flash_io1 = f_wsh[7 - (f_idx % 8)];
    end
  end

  // ---------------- pin timing monitor ----------------
  int   phase_err = 0;
  int   io0_err = 0;
  int   rdy_busy_err = 0;
  int   ph_len = 0;
  int   csb_hi_len = 0;
  int   last_gap = 0;
  logic prev_sck = 1'b0;
  logic prev_io0 = 1'b0;
  bit   chk_timing = 1'b0;

  always @(negedge clock) begin
    if (resetb && busy && req_ready) rdy_busy_err++;
    if (flash_csb !== 1'b0) begin
      ph_len   = 0;
      prev_sck = 1'b0;
      csb_hi_len++;
    end else begin
      if (csb_hi_len != 0) last_gap = csb_hi_len;
      csb_hi_len = 0;
      if (flash_clk !== prev_sck) begin
        if (chk_timing && ph_len != CLK_DIV) phase_err++;
        ph_len = 1;
      end else begin
        ph_len++;
      end
      if (flash_io0 !== prev_io0 && flash_clk) io0_err++;
      prev_sck = flash_clk;
    end
    prev_io0 = flash_io0;
  end

  // ---------------- output monitor ----------------
  logic [32:0] held = '0;
  logic [32:0] exp_w;
  bit          held_v = 1'b0;
  int          stall_err = 0;

  always @(negedge clock) begin
    if (resetb && rd_valid) begin
      if (held_v && {rd_last, rd_data} !== held) stall_err++;
      if (rd_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL rd_extra: got word %h last %0b, expected no word", rd_data, rd_last);
        end else begin
          exp_w = exp_q.pop_front();
          check("rd_word", {31'd0, rd_last, rd_data}, {31'd0, exp_w});
        end
        held_v = 1'b0;
      end else begin
        held   = {rd_last, rd_data};
        held_v = 1'b1;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic [23:0] addr, input logic [LEN_W-1:0] len);
    int n;
    @(posedge clock);
    #1;
    req_addr  = addr;
    req_len   = len;
    req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!req_ready && n < 4000);
    if (!req_ready) fail_wait("req_accept");
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((busy || rd_valid || exp_q.size() != 0) && n < 6000);
    if (n >= 6000) fail_wait(name);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] t1_bytes [5];
  int         n_wait;
  int         r_snap;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    t1_bytes[0] = 8'hAB; t1_bytes[1] = 8'h03; t1_bytes[2] = 8'h00;
    t1_bytes[3] = 8'h00; t1_bytes[4] = 8'h04;

    // Reset values
    resetb = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_csb", flash_csb, 1);
    check("rst_clk", flash_clk, 0);
    check("rst_io0", flash_io0, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    resetb = 1'b1;
    n_wait = 0;
    do begin
      @(negedge clock);
      n_wait++;
    end while (!req_ready && n_wait < 50);
    check("rst_ready_delay", n_wait, CS_GAP);

    // 1: wake-up plus single-word read at 0x4
    chk_timing = 1'b1;
    mosi_log.delete();
    sck_rises = 0;
    exp_q.push_back({1'b1, 32'hDEADBEEF});
    do_req(24'h000004, 8'd1);
    @(negedge clock);
    check("t1_busy", busy, 1);
    wait_idle("t1_idle");
    check("t1_mosi_count", mosi_log.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("t1_mosi_%0d", i), (i < mosi_log.size()) ? mosi_log[i] : 8'hxx, t1_bytes[i]);
    check("t1_wgap_ge", (last_gap >= CS_GAP), 1);
    check("t1_sck_rises", sck_rises, 72);

    // 2: four-word burst, no wake-up this time
    mosi_log.delete();
    sck_rises = 0;
    exp_q.push_back({1'b0, 32'h00000013});
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    exp_q.push_back({1'b0, 32'h12345678});
    exp_q.push_back({1'b1, 32'hCAFEF00D});
    do_req(24'h000000, 8'd4);
    wait_idle("t2_idle");
    check("t2_mosi_count", mosi_log.size(), 4);
    check("t2_first_byte", (mosi_log.size() > 0) ? mosi_log[0] : 8'hxx, 8'h03);
    check("t2_sck_rises", sck_rises, 160);

    // 3: backpressure long enough to force HOLD
    chk_timing = 1'b0;
    sck_rises = 0;
    rd_ready = 1'b0;
    exp_q.push_back({1'b0, 32'h12345678});
    exp_q.push_back({1'b0, 32'hCAFEF00D});
    exp_q.push_back({1'b1, 32'h0BADC0DE});
    do_req(24'h000008, 8'd3);
    n_wait = 0;
    do begin
      @(negedge clock);
      n_wait++;
    end while (!rd_valid && n_wait < 2000);
    if (!rd_valid) fail_wait("t3_first_word");
    @(posedge clock);
    #1 rd_ready = 1'b1;
    @(posedge clock);
    #1 rd_ready = 1'b0;
    repeat (430) @(negedge clock);
    r_snap = sck_rises;
    repeat (70) @(negedge clock);
    check("t3_rises_frozen", sck_rises, r_snap);
    check("t3_hold_clk", flash_clk, 0);
    check("t3_hold_csb", flash_csb, 0);
    check("t3_hold_state", state_dbg, 5);
    @(posedge clock);
    #1 rd_ready = 1'b1;
    wait_idle("t3_idle");
    check("t3_sck_rises", sck_rises, 128);
    check("t3_stall_stable", stall_err, 0);

    // 5: reset in the middle of the data phase
    chk_timing = 1'b1;
    do_req(24'h000010, 8'd2);
    n_wait = 0;
    do begin
      @(negedge clock);
      n_wait++;
    end while (fbits < 42 && n_wait < 2000);
    if (fbits < 42) fail_wait("t5_data_bits");
    @(negedge clock);
    #2 resetb = 1'b0;
    #1;
    check("t5_async_csb", flash_csb, 1);
    check("t5_async_clk", flash_clk, 0);
    check("t5_async_rd_valid", rd_valid, 0);
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    mosi_log.delete();
    sck_rises = 0;
    exp_q.push_back({1'b0, 32'h0BADC0DE});
    exp_q.push_back({1'b1, 32'hA5A55A5A});
    do_req(24'h000010, 8'd2);
    wait_idle("t5_idle");
    check("t5_rewake", (mosi_log.size() > 0) ? mosi_log[0] : 8'hxx, 8'hAB);
    check("t5_mosi_count", mosi_log.size(), 5);
    check("t5_sck_rises", sck_rises, 104);

    // 6: len=0 reads one word; back-to-back with req_valid held high
    sck_rises = 0;
    exp_q.push_back({1'b1, 32'hA5A55A5A});
    exp_q.push_back({1'b1, 32'h0F1E2D3C});
    do_req(24'h000014, 8'd0);
    do_req(24'h000018, 8'd1);
    wait_idle("t6_idle");
    check("t6_sck_rises", sck_rises, 128);
    check("t6_gap_ge", (last_gap >= CS_GAP), 1);

    check("phase_len_errors", phase_err, 0);
    check("io0_high_changes", io0_err, 0);
    check("ready_while_busy", rdy_busy_err, 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
